pll_reset_seq: RTL

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: holds downstream logic in reset until the PLL has reported
// lock continuously for STABLE_CYCLES cycles, then HOLD_CYCLES more, and
// drops the reset again one cycle after lock is seen to go away.
//
// Ports:
//   clk          PLL output clock; all state changes on its rising edge
//   reset_n      synchronous active-low reset
//   locked       PLL lock indicator, asynchronous to clk
//   sys_reset_n  registered active-low reset for downstream logic
//   ready        registered, high only while sequencing has reached RUN
//   lock_lost    one-cycle pulse when lock drops while in RUN
//   lost_count   saturating count of lock_lost pulses
//
// Build option: define PLL_RESET_SEQ_LOSS_COUNT_EN to implement the
// lost_count register; otherwise lost_count is tied to zero.
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lost_count
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STABLE,
    HOLD,
    RUN
  } state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lk_s;
  logic [SW-1:0]        stable_cnt, stable_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic                 lost_nxt;

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= '0;
      state       <= IDLE;
      stable_cnt  <= '0;
      hold_cnt    <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], locked};
      state       <= state_nxt;
      stable_cnt  <= stable_nxt;
      hold_cnt    <= hold_nxt;
      // Outputs are registered from the next state so they always agree
      // with the state register and never depend combinationally on locked.
      sys_reset_n <= (state_nxt == RUN);
      ready       <= (state_nxt == RUN);
      lock_lost   <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    hold_nxt   = hold_cnt;
    lost_nxt   = 1'b0;
    case (state)
      IDLE: begin
        stable_nxt = '0;
        hold_nxt   = '0;
        if (lk_s) begin
          // The cycle that sees lock is already the first stable cycle.
          stable_nxt = SW'(1);
          state_nxt  = (STABLE_CYCLES == 1) ? HOLD : STABLE;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_nxt  = IDLE;
          stable_nxt = '0;
        end else begin
          stable_nxt = stable_cnt + SW'(1);
          if (stable_cnt == STABLE_LAST) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_nxt  = IDLE;
          stable_nxt = '0;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt  = IDLE;
          stable_nxt = '0;
          hold_nxt   = '0;
          lost_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        stable_nxt = '0;
        hold_nxt   = '0;
      end
    endcase
  end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] lost_q;

  // Counts alongside the lock_lost register so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lost_q <= '0;
    end else if (lost_nxt && (lost_q != '1)) begin
      lost_q <= lost_q + 8'd1;
    end
  end

  assign lost_count = lost_q;
`else
  assign lost_count = '0;
`endif

endmodule
